// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the
// RV32I datapath / shared memory port.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state_out;
    logic       illegal;
    logic       fault;

    // Sequencer side: reads instruction fields and flags, drives controls.
    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
               state_out, illegal, fault
    );

    // Datapath side: supplies instruction fields and flags, obeys controls.
    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
               state_out, illegal, fault
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer sharing one memory port for
// instruction and data. Steps fetch/decode/execute/memory/writeback and
// traps on illegal opcodes or a memory request that is never acknowledged.
module multicycle_ctrl_fsm #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    // Moore part of the control word; pc_write here covers only the
    // unconditional jumps, fetch and branch add their qualified terms.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // A request that would reach this many unacknowledged cycles traps.
    localparam logic [8:0] WAIT_LIM = 9'(WAIT_MAX);

    // Control word that applies while the FSM sits in state s.
    function automatic ctrl_t moore_decode(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_EXEC_R:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            S_EXEC_I:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            S_MEM_ADDR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.addr_src = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.addr_src = 1'b1; end
            S_WB_ALU:   begin c.reg_write = 1'b1; end
            S_WB_MEM:   begin c.reg_write = 1'b1; c.wb_sel = 2'b01; end
            S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_src = 2'b01; end
            S_JAL:      begin c.reg_write = 1'b1; c.wb_sel = 2'b10; c.pc_write = 1'b1; c.pc_src = 2'b01; end
            S_JALR:     begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.reg_write = 1'b1;  c.wb_sel = 2'b10;
                c.pc_write  = 1'b1;  c.pc_src = 2'b10;
            end
            S_UPPER:    begin
                c.alu_src_b = 2'b01;
                c.alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_nxt_s;
    logic [8:0] wait_inc_s;
    logic       illegal_r;
    logic       fault_r;
    logic       set_illegal_s;
    logic       set_fault_s;
    logic       taken_s;
    ctrl_t      ctrl_r;

    // Next-state, wait-counter and branch-condition evaluation.
    always_comb begin
        next_s        = state_r;
        wait_nxt_s    = 8'd0;
        set_illegal_s = 1'b0;
        set_fault_s   = 1'b0;
        taken_s       = 1'b0;
        wait_inc_s    = {1'b0, wait_cnt_r} + 9'd1;
        case (state_r)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (bus.mem_ready) begin
                    case (state_r)
                        S_FETCH:  next_s = S_DECODE;
                        S_MEM_RD: next_s = S_WB_MEM;
                        default:  next_s = S_FETCH;
                    endcase
                end else if (wait_inc_s == WAIT_LIM) begin
                    next_s      = S_TRAP;
                    set_fault_s = 1'b1;
                end else begin
                    wait_nxt_s = wait_inc_s[7:0];
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:               next_s = S_EXEC_R;
                    OP_I:               next_s = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_s = S_MEM_ADDR;
                    OP_BRANCH:          next_s = S_BRANCH;
                    OP_JAL:             next_s = S_JAL;
                    OP_JALR:            next_s = S_JALR;
                    OP_LUI, OP_AUIPC:   next_s = S_UPPER;
                    default: begin
                        next_s        = S_TRAP;
                        set_illegal_s = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_UPPER: next_s = S_WB_ALU;
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LOAD) begin
                    next_s = S_MEM_RD;
                end else begin
                    next_s = S_MEM_WR;
                end
            end
            S_WB_ALU, S_WB_MEM, S_JAL, S_JALR: next_s = S_FETCH;
            S_BRANCH: begin
                next_s = S_FETCH;
                // SLT/SLTU set the ALU result to 1 when the condition holds,
                // so BLT/BLTU take on !zero and BGE/BGEU on zero.
                case (bus.funct3)
                    3'b000:         taken_s = bus.zero;
                    3'b001:         taken_s = ~bus.zero;
                    3'b100, 3'b110: taken_s = ~bus.zero;
                    3'b101, 3'b111: taken_s = bus.zero;
                    default: begin
                        taken_s       = 1'b0;
                        next_s        = S_TRAP;
                        set_illegal_s = 1'b1;
                    end
                endcase
            end
            S_TRAP:  next_s = S_TRAP;
            default: next_s = S_TRAP;
        endcase
    end

    // State, wait counter, sticky trap flags and registered Moore controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            illegal_r  <= 1'b0;
            fault_r    <= 1'b0;
            ctrl_r     <= moore_decode(S_FETCH, bus.opcode);
        end else begin
            state_r    <= next_s;
            wait_cnt_r <= wait_nxt_s;
            illegal_r  <= illegal_r | set_illegal_s;
            fault_r    <= fault_r | set_fault_s;
            ctrl_r     <= moore_decode(next_s, bus.opcode);
        end
    end

    // Everything is forced low while reset is held, even mid-transaction.
    assign bus.mem_req   = ~rst & ctrl_r.mem_req;
    assign bus.mem_we    = ~rst & ctrl_r.mem_we;
    assign bus.addr_src  = ~rst & ctrl_r.addr_src;
    assign bus.reg_write = ~rst & ctrl_r.reg_write;
    assign bus.ir_write  = ~rst & (state_r == S_FETCH) & bus.mem_ready;
    assign bus.pc_write  = ~rst & (ctrl_r.pc_write
                                   | ((state_r == S_FETCH) & bus.mem_ready)
                                   | ((state_r == S_BRANCH) & taken_s));
    assign bus.pc_src    = rst ? 2'b00 : ctrl_r.pc_src;
    assign bus.wb_sel    = rst ? 2'b00 : ctrl_r.wb_sel;
    assign bus.alu_src_a = rst ? 2'b00 : ctrl_r.alu_src_a;
    assign bus.alu_src_b = rst ? 2'b00 : ctrl_r.alu_src_b;
    assign bus.alu_op    = rst ? 2'b00 : ctrl_r.alu_op;
    assign bus.state_out = rst ? 4'd0 : state_r;
    assign bus.illegal   = ~rst & illegal_r;
    assign bus.fault     = ~rst & fault_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (instantiated with WAIT_MAX=4).
// Each cycle's whole control word is compared to a hand-built vector.
module tb_multicycle_ctrl_fsm;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(.WAIT_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {bus.state_out, bus.mem_req, bus.mem_we, bus.addr_src,
                  bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                  bus.wb_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.illegal, bus.fault};

    function automatic logic [21:0] e(input logic [3:0] st,
                                      input logic req, we, asrc, ir, pcw,
                                      input logic [1:0] pcs,
                                      input logic rw,
                                      input logic [1:0] wb, a, b, op,
                                      input logic ill, flt);
        return {st, req, we, asrc, ir, pcw, pcs, rw, wb, a, b, op, ill, flt};
    endfunction

    localparam logic [21:0] V_RST        = 22'd0;
    localparam logic [21:0] V_FETCH_RDY  = e(4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_FETCH_WAIT = e(4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_DECODE     = e(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_EXEC_R     = e(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0);
    localparam logic [21:0] V_EXEC_I     = e(4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd2, 1'b0, 1'b0);
    localparam logic [21:0] V_MEM_ADDR   = e(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_MEM_RD     = e(4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_MEM_WR     = e(4'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_WB_ALU     = e(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_WB_MEM     = e(4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_BR_TAKEN   = e(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
    localparam logic [21:0] V_BR_NOT     = e(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
    localparam logic [21:0] V_JAL        = e(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_JALR       = e(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_LUI        = e(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_AUIPC      = e(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
    localparam logic [21:0] V_TRAP_ILL   = e(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    localparam logic [21:0] V_TRAP_FLT   = e(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);

    // One reset cycle, leaving the DUT in FETCH with a cleared wait count.
    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== V_RST) begin
            errors++;
            $display("FAIL reset_hold: got %h, expected %h", obs, V_RST);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_release: got %h, expected %h", obs, V_FETCH_WAIT);
        end
        @(posedge clk); #1;
    endtask

    // Reset lands during a 3-wait load; the following fetch waits 3 more
    // cycles, which only succeeds if the wait count was cleared.
    task automatic test_reset_mid_mem_rd();
        logic [21:0] exp_v [12] = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD,
                                    V_RST, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_RDY, V_DECODE};
        logic        rdy_v [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        rst_v [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        bus.opcode = 7'b0000011;
        for (int i = 0; i < 12; i++) begin
            rst = rst_v[i];
            bus.mem_ready = rdy_v[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_mid_mem_rd[%0d]: got %h, expected %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [21:0] exp_v [5] = '{V_FETCH_RDY, V_DECODE, V_EXEC_R, V_WB_ALU, V_FETCH_WAIT};
        logic        rdy_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.opcode = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy_v[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL add[%0d]: got %h, expected %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Load with the data ack on the 4th MEM_RD cycle (count = WAIT_MAX-1).
    task automatic test_load_wait();
        logic [21:0] exp_v [9] = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD,
                                   V_MEM_RD, V_WB_MEM, V_FETCH_WAIT};
        logic        rdy_v [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        bus.opcode = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = rdy_v[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL load_wait[%0d]: got %h, expected %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [21:0] exp_v [6] = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_WR, V_MEM_WR, V_FETCH_WAIT};
        logic        rdy_v [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.opcode = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = rdy_v[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL store[%0d]: got %h, expected %h", i, obs, exp_v[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3_v   [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
        logic        zero_v [7] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
        logic [21:0] br_v   [7] = '{V_BR_TAKEN, V_BR_NOT, V_BR_TAKEN, V_BR_NOT, V_BR_NOT, V_BR_TAKEN, V_BR_NOT};
        logic [21:0] aft_v  [7] = '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT,
                                    V_FETCH_WAIT, V_FETCH_WAIT, V_TRAP_ILL};
        logic [21:0] exp_v  [4];
        for (int k = 0; k < 7; k++) begin
            do_reset();
            bus.opcode = 7'b1100011;
            bus.funct3 = f3_v[k];
            bus.zero   = zero_v[k];
            exp_v = '{V_FETCH_RDY, V_DECODE, br_v[k], aft_v[k]};
            for (int i = 0; i < 4; i++) begin
                bus.mem_ready = (i == 0) ? 1'b1 : 1'b0;
                @(negedge clk);
                checks++;
                if (obs !== exp_v[i]) begin
                    errors++;
                    $display("FAIL branch f3=%b zero=%b [%0d]: got %h, expected %h",
                             f3_v[k], zero_v[k], i, obs, exp_v[i]);
                end
                @(posedge clk); #1;
            end
        end
        bus.zero = 1'b0;
        bus.funct3 = 3'b000;
    endtask

    task automatic test_jump_upper();
        logic [6:0]  op_v [5] = '{7'b1101111, 7'b1100111, 7'b0010011, 7'b0110111, 7'b0010111};
        logic [21:0] c2_v [5] = '{V_JAL, V_JALR, V_EXEC_I, V_LUI, V_AUIPC};
        logic [21:0] c3_v [5] = '{V_FETCH_WAIT, V_FETCH_WAIT, V_WB_ALU, V_WB_ALU, V_WB_ALU};
        logic [21:0] exp_v [5];
        for (int k = 0; k < 5; k++) begin
            do_reset();
            bus.opcode = op_v[k];
            exp_v = '{V_FETCH_RDY, V_DECODE, c2_v[k], c3_v[k], V_FETCH_WAIT};
            for (int i = 0; i < 5; i++) begin
                bus.mem_ready = (i == 0) ? 1'b1 : 1'b0;
                @(negedge clk);
                checks++;
                if (obs !== exp_v[i]) begin
                    errors++;
                    $display("FAIL jump_upper op=%b [%0d]: got %h, expected %h", op_v[k], i, obs, exp_v[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    // Illegal opcode traps, holds 20 more cycles, then only reset clears it.
    task automatic test_illegal();
        logic [21:0] exp_q [$];
        logic        rdy_q [$];
        logic        rst_q [$];
        do_reset();
        bus.opcode = 7'b1111111;
        exp_q = '{V_FETCH_RDY, V_DECODE};
        rdy_q = '{1'b1, 1'b0};
        rst_q = '{1'b0, 1'b0};
        for (int k = 0; k < 21; k++) begin
            exp_q.push_back(V_TRAP_ILL);
            rdy_q.push_back(k[0]);
            rst_q.push_back(1'b0);
        end
        exp_q.push_back(V_RST);        rdy_q.push_back(1'b0); rst_q.push_back(1'b1);
        exp_q.push_back(V_FETCH_WAIT); rdy_q.push_back(1'b0); rst_q.push_back(1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            rst = rst_q[i];
            bus.mem_ready = rdy_q[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL illegal[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Fetch never acknowledged traps after 4 waits; an ack on the 4th is fine.
    task automatic test_timeout();
        logic [21:0] exp_a [7] = '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT,
                                   V_TRAP_FLT, V_TRAP_FLT, V_TRAP_FLT};
        logic        rdy_a [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [21:0] exp_b [5] = '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_RDY, V_DECODE};
        logic        rdy_b [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.opcode = 7'b0110011;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = rdy_a[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_a[i]) begin
                errors++;
                $display("FAIL timeout[%0d]: got %h, expected %h", i, obs, exp_a[i]);
            end
            @(posedge clk); #1;
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy_b[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_b[i]) begin
                errors++;
                $display("FAIL timeout_edge[%0d]: got %h, expected %h", i, obs, exp_b[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.opcode = 7'b0000000;
        bus.funct3 = 3'b000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_reset_mid_mem_rd();
        test_add();
        test_load_wait();
        test_store();
        test_branch();
        test_jump_upper();
        test_illegal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
